imem_loader: RTL

//   Boot-time writer for the instruction memory that the CPU's InstrMem port reads.
//   It receives a length-prefixed byte stream over a valid/ready handshake and packs
//   the bytes into 32-bit words. Each word is written to consecutive word-aligned

---
 rtl/imem_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: packs a length-prefixed byte stream into 32-bit instruction memory writes.
// Latency: wr_en one cycle after the 4th byte of a word; done one cycle after the last write. in_ready drops only in DONE/ERR or the post-write cycle.
// Backpressure: valid/ready on the byte stream, 1 byte/cycle sustained; no backpressure from the memory side.
module imem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        error
);

    localparam int IDX_W  = $clog2(DEPTH + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        len;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         byte_cnt;
    logic [23:0]        word_sr;
    logic [IDLE_W-1:0]  idle_cnt;

    logic               accept;
    logic               idle_expired;
    logic               all_written;
    logic [15:0]        len_rx;

    assign accept       = in_valid && in_ready;
    assign len_rx       = {len[15:8], in_data};
    // Uses in_valid rather than accept so the FSM never reads its own in_ready.
    assign idle_expired = (idle_cnt == IDLE_LAST) && !in_valid;
    // idx counts issued writes; equality with len means the last word went out last cycle.
    assign all_written  = (16'(idx) == len);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LEN_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (len_rx == 16'd0) begin
                        state_nxt = DONE;
                    end else if (len_rx > 16'(DEPTH)) begin
                        state_nxt = ERR;
                    end else begin
                        state_nxt = DATA;
                    end
                end else if (idle_expired) begin
                    state_nxt = ERR;
                end
            end
            DATA: begin
                if (all_written) begin
                    state_nxt = DONE;
                end else begin
                    in_ready = 1'b1;
                    if (idle_expired) begin
                        state_nxt = ERR;
                    end
                end
            end
            DONE:    state_nxt = DONE;
            ERR:     state_nxt = ERR;
            default: state_nxt = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= BASE_ADDR;
            wr_data  <= 32'h0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            len      <= 16'h0;
            idx      <= '0;
            byte_cnt <= 2'd0;
            word_sr  <= 24'h0;
            idle_cnt <= '0;
        end else begin
            wr_en <= 1'b0;

            if ((state == LEN_LO || state == DATA) && !accept) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (accept) begin
                case (state)
                    LEN_HI: len[15:8] <= in_data;
                    LEN_LO: len[7:0]  <= in_data;
                    DATA: begin
                        word_sr  <= {word_sr[15:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            wr_en   <= 1'b1;
                            wr_data <= {word_sr, in_data};
                            wr_addr <= BASE_ADDR + (32'(idx) << 2);
                            idx     <= idx + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end

            if (state_nxt == DONE) begin
                done    <= 1'b1;
                cpu_rst <= 1'b0;
            end
            if (state_nxt == ERR) begin
                error <= 1'b1;
            end
        end
    end

endmodule
